// File: rtl/prio_tree_sel.sv
// Pipelined priority-select tree for the TCAM confirm stage: picks the matching
// rule with the best (max or min) priority across NCH confirm channels.
module prio_tree_sel #(
   parameter  int NCH    = 13,
   parameter  int IDWID  = 8,
   parameter  int PRIOR  = 8,
   parameter  int CNTWID = 32,
   localparam int CFWID  = 1 + IDWID + PRIOR,
   localparam int CHWID  = (NCH > 1) ? $clog2(NCH) : 1,
   localparam int NLVL   = $clog2(NCH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_en,
   input  logic                   i_valid,
   input  logic                   i_mode_min,
   input  logic [NCH*CFWID-1:0]   i_result,
   input  logic                   i_clr_cnt,
   output logic                   o_valid,
   output logic                   o_hit,
   output logic [IDWID-1:0]       o_ruleid,
   output logic [PRIOR-1:0]       o_prio,
   output logic [CHWID-1:0]       o_chan,
   output logic [CHWID:0]         o_nmatch,
   output logic [CNTWID-1:0]      o_hit_cnt
);

   // Stage 0 holds the leaves, stage l holds tree level l; the last stage is the output.
   logic             r_match [0:NLVL][0:NCH-1];
   logic [IDWID-1:0] r_id    [0:NLVL][0:NCH-1];
   logic [PRIOR-1:0] r_prio  [0:NLVL][0:NCH-1];
   logic [CHWID-1:0] r_chan  [0:NLVL][0:NCH-1];
   logic [CHWID:0]   r_nm    [0:NLVL][0:NCH-1];
   logic             r_valid [0:NLVL];
   logic             r_mode  [0:NLVL];
   logic             r_oval;
   logic [CNTWID-1:0] r_cnt;

   logic             w_match [0:NLVL][0:NCH-1];
   logic [IDWID-1:0] w_id    [0:NLVL][0:NCH-1];
   logic [PRIOR-1:0] w_prio  [0:NLVL][0:NCH-1];
   logic [CHWID-1:0] w_chan  [0:NLVL][0:NCH-1];
   logic [CHWID:0]   w_nm    [0:NLVL][0:NCH-1];
   logic             w_valid [0:NLVL];
   logic             w_mode  [0:NLVL];

   function automatic int lvl_nodes(input int lvl);
      int n;
      n = NCH;
      for (int i = 0; i < lvl; i++) n = (n + 1) / 2;
      return n;
   endfunction

   always_comb begin
      int np, ia, ib, src;
      logic a_wins;
      np = 0; ia = 0; ib = 0; src = 0; a_wins = 1'b0;
      for (int l = 0; l <= NLVL; l++) begin
         w_valid[l] = 1'b0;
         w_mode[l]  = 1'b0;
         for (int k = 0; k < NCH; k++) begin
            w_match[l][k] = 1'b0;
            w_id[l][k]    = '0;
            w_prio[l][k]  = '0;
            w_chan[l][k]  = '0;
            w_nm[l][k]    = '0;
         end
      end

      // Non-matching leaves carry an all-zero payload so every losing or empty
      // node downstream is zero without extra masking at the output.
      w_valid[0] = i_valid;
      w_mode[0]  = i_mode_min;
      for (int k = 0; k < NCH; k++) begin
         if (i_result[k*CFWID + CFWID - 1]) begin
            w_match[0][k] = 1'b1;
            w_id[0][k]    = i_result[k*CFWID + PRIOR +: IDWID];
            w_prio[0][k]  = i_result[k*CFWID +: PRIOR];
            w_chan[0][k]  = CHWID'(k);
            w_nm[0][k]    = {{CHWID{1'b0}}, 1'b1};
         end
      end

      for (int l = 1; l <= NLVL; l++) begin
         np = lvl_nodes(l - 1);
         w_valid[l] = r_valid[l-1];
         w_mode[l]  = r_mode[l-1];
         for (int j = 0; j < (NCH + 1) / 2; j++) begin
            ia = 2 * j;
            ib = (2 * j + 1 < NCH) ? 2 * j + 1 : 2 * j;
            if (2 * j + 1 < np) begin
               // Ties resolve toward the lower channel via the inclusive compare.
               a_wins = !r_match[l-1][ib] ||
                        (r_match[l-1][ia] &&
                         (r_mode[l-1] ? (r_prio[l-1][ia] <= r_prio[l-1][ib])
                                      : (r_prio[l-1][ia] >= r_prio[l-1][ib])));
               src = a_wins ? ia : ib;
               w_match[l][j] = r_match[l-1][src];
               w_id[l][j]    = r_id[l-1][src];
               w_prio[l][j]  = r_prio[l-1][src];
               w_chan[l][j]  = r_chan[l-1][src];
               w_nm[l][j]    = r_nm[l-1][ia] + r_nm[l-1][ib];
            end else if (2 * j < np) begin
               w_match[l][j] = r_match[l-1][ia];
               w_id[l][j]    = r_id[l-1][ia];
               w_prio[l][j]  = r_prio[l-1][ia];
               w_chan[l][j]  = r_chan[l-1][ia];
               w_nm[l][j]    = r_nm[l-1][ia];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_oval <= 1'b0;
         for (int l = 0; l <= NLVL; l++) begin
            r_valid[l] <= 1'b0;
            r_mode[l]  <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
               r_match[l][k] <= 1'b0;
               r_id[l][k]    <= '0;
               r_prio[l][k]  <= '0;
               r_chan[l][k]  <= '0;
               r_nm[l][k]    <= '0;
            end
         end
      end else begin
         // A stalled cycle never re-emits the frozen final stage.
         r_oval <= i_en & w_valid[NLVL];
         if (i_en) begin
            for (int l = 0; l <= NLVL; l++) begin
               r_valid[l] <= w_valid[l];
               r_mode[l]  <= w_mode[l];
               for (int k = 0; k < NCH; k++) begin
                  r_match[l][k] <= w_match[l][k];
                  r_id[l][k]    <= w_id[l][k];
                  r_prio[l][k]  <= w_prio[l][k];
                  r_chan[l][k]  <= w_chan[l][k];
                  r_nm[l][k]    <= w_nm[l][k];
               end
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || i_clr_cnt) begin
         r_cnt <= '0;
      end else if (r_oval && r_match[NLVL][0] && (r_cnt != {CNTWID{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign o_valid   = r_oval;
   assign o_hit     = r_match[NLVL][0];
   assign o_ruleid  = r_id[NLVL][0];
   assign o_prio    = r_prio[NLVL][0];
   assign o_chan    = r_chan[NLVL][0];
   assign o_nmatch  = r_nm[NLVL][0];
   assign o_hit_cnt = r_cnt;

endmodule
